// File: rtl/mult_scheduler_if.sv
// Handshake and operand bundle between the two requesters and the shared
// add-shift multiplier scheduler.
interface mult_scheduler_if #(
    parameter int WIDTH = 8
);
    logic [1:0]         req;
    logic [WIDTH-1:0]   opa0;
    logic [WIDTH-1:0]   opb0;
    logic [WIDTH-1:0]   opa1;
    logic [WIDTH-1:0]   opb1;
    logic [1:0]         gnt;
    logic               busy;
    logic [1:0]         done;
    logic [2*WIDTH-1:0] product;

    // Front-end side: raises requests and supplies operands.
    modport master (
        output req, opa0, opb0, opa1, opb1,
        input  gnt, busy, done, product
    );

    // Scheduler side: arbitrates and returns the product.
    modport slave (
        input  req, opa0, opb0, opa1, opb1,
        output gnt, busy, done, product
    );
endinterface

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one signed add-shift multiplier between two
// requesters. Runs WIDTH add/shift iterations (subtract on the last one) and
// returns a 2*WIDTH-bit two's-complement product with a per-requester done.
module mult_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mult_scheduler_if.slave io_bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADD   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Maps a requester index onto its one-hot grant/done position.
    function automatic logic [1:0] f_onehot(input logic idx);
        logic [1:0] v;
        if (idx) begin
            v = 2'b10;
        end else begin
            v = 2'b01;
        end
        return v;
    endfunction

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_x;
    logic [CW-1:0]      r_cnt;
    logic               r_owner;
    logic               r_last;
    logic [1:0]         r_gnt;
    logic               r_busy;
    logic [1:0]         r_done;
    logic [2*WIDTH-1:0] r_product;

    logic               w_pick;
    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sh_a;
    logic [WIDTH-1:0]   w_sh_b;

    // Arbitration: a lone request wins outright; a tie goes to the requester not served last.
    always_comb begin
        w_pick = 1'b0;
        case (io_bus.req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~r_last;
            default: w_pick = 1'b0;
        endcase
    end

    // Operand selection for the requester being picked this cycle.
    always_comb begin
        w_opa = io_bus.opa0;
        w_opb = io_bus.opb0;
        if (w_pick) begin
            w_opa = io_bus.opa1;
            w_opb = io_bus.opb1;
        end else begin
            w_opa = io_bus.opa0;
            w_opb = io_bus.opb0;
        end
    end

    // Sign-extended accumulate; the final iteration weighs the multiplier MSB negatively.
    always_comb begin
        w_sum = {r_a[WIDTH-1], r_a} + {r_s[WIDTH-1], r_s};
        if (r_cnt == LAST_CNT) begin
            w_sum = {r_a[WIDTH-1], r_a} - {r_s[WIDTH-1], r_s};
        end else begin
            w_sum = {r_a[WIDTH-1], r_a} + {r_s[WIDTH-1], r_s};
        end
    end

    // Arithmetic right shift of {X,A,B}; X replicates into the top of A.
    always_comb begin
        w_sh_a = {r_x, r_a[WIDTH-1:1]};
        w_sh_b = {r_a[0], r_b[WIDTH-1:1]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_s       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_x       <= 1'b0;
            r_cnt     <= '0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_gnt     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 2'b00;
            r_product <= '0;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.req != 2'b00) begin
                        r_owner <= w_pick;
                        r_s     <= w_opa;
                        r_b     <= w_opb;
                        r_a     <= '0;
                        r_x     <= 1'b0;
                        r_cnt   <= '0;
                        r_gnt   <= f_onehot(w_pick);
                        r_busy  <= 1'b1;
                        r_state <= ST_ADD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    if (r_b[0]) begin
                        r_a <= w_sum[WIDTH-1:0];
                        r_x <= w_sum[WIDTH];
                    end else begin
                        r_a <= r_a;
                    end
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_a   <= w_sh_a;
                    r_b   <= w_sh_b;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        // Product and done are registered on entry to DONE.
                        r_product <= {w_sh_a, w_sh_b};
                        r_done    <= f_onehot(r_owner);
                        r_state   <= ST_DONE;
                    end else begin
                        r_state <= ST_ADD;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_owner;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.gnt     = r_gnt;
    assign io_bus.busy    = r_busy;
    assign io_bus.done    = r_done;
    assign io_bus.product = r_product;

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Shares one 8-bit signed add-shift multiplier between two requesters. Round-robin arbitration selects a requester, captures its operands, and sequences WIDTH add/shift iterations (subtract on the last). The block returns a 2·WIDTH-bit two's-complement product with a per-requester done pulse. It sits between the switch/host front ends and the multiplier datapath, replacing a single-user Run-driven control FSM.

## Interface
- WIDTH, 8, operand width; product is 2·WIDTH; iteration counter is clog2(WIDTH) bits.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; returns to IDLE and clears all outputs.
- req  in  2  request bits; req[i] high means requester i wants a multiply.
- opa0, opb0  in  WIDTH each  requester 0 multiplicand (opa0) and multiplier (opb0), signed.
- opa1, opb1  in  WIDTH each  requester 1 operands, signed.
- gnt  out  2  one-hot owner of the unit; 0 when idle.
- busy  out  1  high in ADD, SHIFT and DONE.
- done  out  2  one-cycle pulse on done[owner] in DONE.
- product  out  2·WIDTH  signed result; valid from DONE and held until the next capture.

## Operation
- Internal registers:
  - S: multiplicand.
  - A: upper half.
  - B: multiplier / lower half.
  - X: sign extension bit.
  - cnt: iteration counter.
  - owner.
  - last: the last-served requester.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - If req is 0, stay in IDLE.
  - If exactly one req bit is set, pick that requester.
  - If both are set, pick the requester that is not `last`.
  - At that edge: owner <= pick, S <= opa[pick], B <= opb[pick], A <= 0, X <= 0, cnt <= 0. Go to ADD.
- ADD:
  - If B[0] = 1, form a WIDTH+1-bit sign-extended sum: {A[msb],A} + {S[msb],S}.
  - When cnt = WIDTH-1, subtract S instead of adding it.
  - Write A <= sum[WIDTH-1:0] and X <= sum[WIDTH].
  - If B[0] = 0, A and X are unchanged.
  - Go to SHIFT.
- SHIFT:
  - Arithmetic right shift of {X,A,B} by one; X keeps its value.
  - Increment cnt.
  - If cnt was WIDTH-1, go to DONE; otherwise go to ADD.
- DONE:
  - product = {A,B}; done[owner] = 1; last <= owner.
  - Go to IDLE unconditionally.
- gnt = one-hot(owner) in ADD, SHIFT and DONE; 0 in IDLE.
- req handling:
  - req is sampled only in IDLE.
  - Deasserting req mid-operation does not abort; the operation completes and done still pulses.
  - Operands only need to be valid in the IDLE cycle where the requester is picked.
- A requester that holds req high after its done is re-served at the next IDLE. If the other requester is also asking, round-robin serves the other one first.
- Full-range operands are exact: -2^(WIDTH-1) × -2^(WIDTH-1) = +2^(2·WIDTH-2). No overflow is possible, thanks to the WIDTH+1-bit sum.

## Timing
- Capture edge t (IDLE→ADD) is the first edge with req ≠ 0 in IDLE.
- ADD/SHIFT occupy 2·WIDTH cycles, t+1 through t+2·WIDTH (16 for WIDTH=8).
- DONE is the cycle after edge t+2·WIDTH+1:
  - done and the valid product appear 17 cycles after the capture edge for WIDTH=8.
  - product is registered on entry to DONE.
- IDLE lasts at least one cycle between operations, so back-to-back throughput is 2·WIDTH+2 cycles per multiply.
- gnt and busy rise in the first ADD cycle and fall in the first IDLE cycle.
- Reset values: gnt = 0, busy = 0, done = 0, product = 0, state IDLE, cnt = 0, A = B = S = X = 0.
  - last = 1, so requester 0 wins the first tie.
- Reset mid-operation:
  - Next cycle: IDLE with all reset values.
  - No done pulse; the partial result is discarded and product = 0.
- Reset and req high together: reset wins; arbitration happens at the earliest on the first edge after Reset falls.

## Test plan
- Reset for 1 cycle with random inputs → gnt = 0, busy = 0, done = 0, product = 0x0000.
- req = 01, opa0 = 0x07, opb0 = 0xFD, one-cycle req → gnt = 01 from t+1, done = 01 pulse exactly 17 cycles after capture, product = 0xFFEB (-21), held afterward.
- Corner operands on requester 0:
  - 0x80 × 0x80 → 0x4000.
  - 0x7F × 0x7F → 0x3F01.
  - 0x80 × 0x7F → 0xC080.
  - 0x00 × 0x9C → 0x0000.
- req = 11 held after reset, opa0/opb0 = 0x03/0x05, opa1/opb1 = 0xFF/0xFF:
  - First grant 01 → product 0x000F.
  - Then grant 10 → product 0x0001.
  - Grants keep alternating 01/10 every 18 cycles.
- Start an operation, drop req at t+3 → operation completes, done pulses on schedule, no new grant follows.
- Assert Reset at t+8 of an operation → IDLE next cycle, gnt = 0, product = 0x0000, no done pulse. A req = 10 afterward is served normally.
